// File: rtl/line_fill_mem.sv
// line_fill_mem: backing-memory responder for cache line refill and write-back bursts.
// Optional feature macro CRITICAL_WORD_FIRST_EN: refills start at the requested word and wrap.
module line_fill_mem #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LINE_WORDS  = 4,
   parameter int unsigned LATENCY     = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] wdata,
   input  logic        wdata_valid,
   output logic        wdata_ready,
   output logic [31:0] rdata,
   output logic        rvalid,
   output logic        rlast,
   output logic        wdone
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned BW = $clog2(LINE_WORDS);
   localparam int unsigned CW = $clog2(LATENCY + 1);
   localparam int unsigned TW = AW - BW;

   typedef enum logic [2:0] {StIdle, StWait, StRburst, StWburst, StWack} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [BW-1:0] beat_q, beat_d;
   logic [TW-1:0] line_q, line_d;
   logic          we_q, we_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          rvalid_q, rvalid_d;
   logic          rlast_q, rlast_d;

   logic [BW-1:0] start_off;
   logic [AW-1:0] rd_idx;
   logic [AW-1:0] wr_idx;
   logic          issue_beat;
   logic          mem_we;
   logic          unused_addr;

   logic [31:0]   mem [DEPTH_WORDS];

`ifdef CRITICAL_WORD_FIRST_EN
   logic [BW-1:0] start_q, start_d;

   assign start_off   = start_q;
   assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};

   always_comb begin
      start_d = start_q;
      if (state_q == StIdle && req_valid) begin
         // Write-backs always begin at word 0; only refills honour the critical word.
         start_d = req_we ? '0 : req_addr[BW+1:2];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         start_q <= '0;
      end else begin
         start_q <= start_d;
      end
   end
`else
   assign start_off   = '0;
   assign unused_addr = ^{req_addr[31:AW+2], req_addr[BW+1:0]};
`endif

   assign rd_idx = {line_q, start_off + beat_q};
   assign wr_idx = {line_q, beat_q};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      beat_d     = beat_q;
      line_d     = line_q;
      we_d       = we_q;
      rdata_d    = '0;
      rvalid_d   = 1'b0;
      rlast_d    = 1'b0;
      issue_beat = 1'b0;
      mem_we     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               state_d = StWait;
               cnt_d   = CW'(LATENCY);
               beat_d  = '0;
               line_d  = req_addr[AW+1:BW+2];
               we_d    = req_we;
            end
         end
         StWait: begin
            if (cnt_q == '0) begin
               if (we_q) begin
                  state_d = StWburst;
               end else begin
                  state_d    = StRburst;
                  issue_beat = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         StRburst: begin
            if (rlast_q) begin
               state_d = StIdle;
               beat_d  = '0;
            end else begin
               issue_beat = 1'b1;
            end
         end
         StWburst: begin
            if (wdata_valid) begin
               mem_we = 1'b1;
               beat_d = beat_q + BW'(1);
               if (beat_q == BW'(LINE_WORDS - 1)) begin
                  state_d = StWack;
               end
            end
         end
         StWack: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Refill beats are registered: the word for the next cycle is fetched here.
      if (issue_beat) begin
         rvalid_d = 1'b1;
         rdata_d  = mem[rd_idx];
         rlast_d  = (beat_q == BW'(LINE_WORDS - 1));
         beat_d   = beat_q + BW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         beat_q   <= '0;
         line_q   <= '0;
         we_q     <= 1'b0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         rlast_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         beat_q   <= beat_d;
         line_q   <= line_d;
         we_q     <= we_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         rlast_q  <= rlast_d;
      end
   end

   // Storage keeps its contents across reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wr_idx] <= wdata;
      end
   end

   assign req_ready   = (state_q == StIdle);
   assign wdata_ready = (state_q == StWburst);
   assign wdone       = (state_q == StWack);
   assign rdata       = rdata_q;
   assign rvalid      = rvalid_q;
   assign rlast       = rlast_q;

endmodule

// File: tb/tb_line_fill_mem.sv
// Bench for line_fill_mem: random bursts checked each cycle against a transaction-level model,
// plus directed literal checks. Follows CRITICAL_WORD_FIRST_EN when defined.
module tb_line_fill_mem;

   localparam int DEPTH = 1024;
   localparam int LW    = 4;
   localparam int LAT   = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] wdata = '0;
   logic        wdata_valid = 1'b0;
   logic        req_ready;
   logic        wdata_ready;
   logic [31:0] rdata;
   logic        rvalid;
   logic        rlast;
   logic        wdone;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   // Transaction-level model: phase is derived from cycles elapsed since accept.
   logic [31:0] mem_m [DEPTH];
   bit m_busy = 1'b0;
   bit m_we = 1'b0;
   bit m_ack = 1'b0;
   int m_t = 0;
   int m_wcnt = 0;
   int m_base = 0;
   int m_start = 0;
   int mw;
   int wc;

   bit e_rv;
   bit e_wr;
   bit e_wd;
   int e_beat;

   logic [31:0] cap [$];
   int first_cyc = -1;
   int last_pos = -1;
   int wdone_cnt = 0;
   bit log_acc = 1'b0;
   int acc_log [$];
   logic [31:0] wbuf [LW];

   line_fill_mem #(
      .DEPTH_WORDS(DEPTH),
      .LINE_WORDS (LW),
      .LATENCY    (LAT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .wdata      (wdata),
      .wdata_valid(wdata_valid),
      .wdata_ready(wdata_ready),
      .rdata      (rdata),
      .rvalid     (rvalid),
      .rlast      (rlast),
      .wdone      (wdone)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy <= 1'b0;
         m_ack  <= 1'b0;
      end else if (!m_busy) begin
         if (req_valid) begin
            mw = int'((req_addr >> 2) % DEPTH);
            m_busy <= 1'b1;
            m_we   <= req_we;
            m_t    <= 0;
            m_wcnt <= 0;
            m_ack  <= 1'b0;
            m_base <= mw - (mw % LW);
`ifdef CRITICAL_WORD_FIRST_EN
            m_start <= req_we ? 0 : (mw % LW);
`else
            m_start <= 0;
`endif
         end
      end else if (m_we) begin
         if (m_ack) begin
            m_busy <= 1'b0;
         end else begin
            wc = m_wcnt;
            if (m_t >= LAT + 1 && wdata_valid) begin
               mem_m[m_base + wc] <= wdata;
               wc = wc + 1;
            end
            m_wcnt <= wc;
            m_t    <= m_t + 1;
            if (wc == LW) m_ack <= 1'b1;
         end
      end else begin
         m_t <= m_t + 1;
         if (m_t + 1 > LAT + LW) m_busy <= 1'b0;
      end
   end

   always @(negedge clk) begin
      e_rv = m_busy && !m_we && (m_t >= LAT + 1);
      e_wr = m_busy && m_we && !m_ack && (m_t >= LAT + 1);
      e_wd = m_busy && m_we && m_ack;
      chk1("req_ready", req_ready, !m_busy);
      chk1("rvalid", rvalid, e_rv);
      chk1("rlast", rlast, e_rv && (m_t == LAT + LW));
      chk1("wdata_ready", wdata_ready, e_wr);
      chk1("wdone", wdone, e_wd);
      if (e_rv) begin
         e_beat = m_t - LAT - 1;
         chk32("rdata", rdata, mem_m[m_base + ((m_start + e_beat) % LW)]);
      end
   end

   always @(negedge clk) begin
      if (rvalid) begin
         if (cap.size() == 0) first_cyc = cyc;
         cap.push_back(rdata);
         if (rlast) last_pos = cap.size();
      end
      if (wdone) wdone_cnt++;
      if (log_acc && req_valid && req_ready) acc_log.push_back(cyc + 1);
   end

   // All driving tasks start and end 2 time units after a rising edge.
   task automatic wait_accept(output int acc);
      bit rr;
      acc = -1;
      for (int b = 0; b < 60; b++) begin
         rr = req_ready;
         @(posedge clk);
         #2;
         if (rr) begin
            acc = cyc;
            break;
         end
      end
      if (acc < 0) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: got no accept expected accept within 60 cycles");
      end
   endtask

   task automatic do_write(input logic [31:0] addr, input int mode, input bit chk_done);
      int acc;
      int n;
      int gaps;
      bit rdy;
      bit v;
      req_we    = 1'b1;
      req_addr  = addr;
      req_valid = 1'b1;
      wait_accept(acc);
      req_valid = 1'b0;
      n = 0;
      gaps = 0;
      for (int b = 0; b < 80 && n < LW; b++) begin
         rdy = wdata_ready;
         case (mode)
            0:       v = 1'b1;
            1:       v = ($urandom % 3) != 0;
            default: v = !(n == 1 && gaps < 2);
         endcase
         if (rdy && !v && n == 1) gaps++;
         wdata_valid = v;
         wdata       = wbuf[n];
         @(posedge clk);
         #2;
         if (v && rdy) n++;
      end
      wdata_valid = 1'b0;
      chk32("wr_beats", n, LW);
      if (chk_done) begin
         chk1("wdone_after_last", wdone, 1'b1);
         @(posedge clk);
         #2;
         chk1("wdone_one_cycle", wdone, 1'b0);
      end
   endtask

   task automatic do_read(input logic [31:0] addr, input bit capture, input int waitc,
                          output int acc);
      req_we    = 1'b0;
      req_addr  = addr;
      req_valid = 1'b1;
      if (capture) begin
         cap.delete();
         first_cyc = -1;
         last_pos  = -1;
      end
      wait_accept(acc);
      req_valid = 1'b0;
      repeat (waitc) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic chk_line(input string name, input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
      chk32({name, "_beats"}, cap.size(), 4);
      while (cap.size() < 4) cap.push_back(32'hDEAD_BEEF);
      chk32({name, "_w0"}, cap[0], e0);
      chk32({name, "_w1"}, cap[1], e1);
      chk32({name, "_w2"}, cap[2], e2);
      chk32({name, "_w3"}, cap[3], e3);
      chk32({name, "_rlast_pos"}, last_pos, 4);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int acc;
      int wd0;
      int n;
      logic [31:0] a;

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      chk1("rst_req_ready", req_ready, 1'b1);
      chk1("rst_wdata_ready", wdata_ready, 1'b0);
      chk1("rst_rvalid", rvalid, 1'b0);
      chk1("rst_rlast", rlast, 1'b0);
      chk1("rst_wdone", wdone, 1'b0);
      chk32("rst_rdata", rdata, 32'h0);
      reset = 1'b0;
      @(posedge clk);
      #2;

      // Give every word a known value.
      for (int l = 0; l < DEPTH / LW; l++) begin
         for (int i = 0; i < LW; i++) wbuf[i] = $urandom;
         do_write(32'(l * LW * 4), 0, 1'b0);
      end

      wbuf[0] = 32'hA0A0_0000;
      wbuf[1] = 32'hA1A1_1111;
      wbuf[2] = 32'hA2A2_2222;
      wbuf[3] = 32'hA3A3_3333;
      do_write(32'h0000_0100, 0, 1'b1);
      chk32("model_pin_w64", mem_m[64], 32'hA0A0_0000);
      chk32("model_pin_w67", mem_m[67], 32'hA3A3_3333);
      do_read(32'h0000_0100, 1'b1, LAT + LW + 2, acc);
      chk32("first_beat_latency", first_cyc - acc, 4);
      chk_line("rd100", 32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333);

      wbuf[0] = 32'hB000_0000;
      wbuf[1] = 32'hB111_0001;
      wbuf[2] = 32'hB222_0002;
      wbuf[3] = 32'hB333_0003;
      wd0 = wdone_cnt;
      do_write(32'h0000_0200, 2, 1'b1);
      repeat (3) begin
         @(posedge clk);
         #2;
      end
      chk32("gap_wdone_count", wdone_cnt - wd0, 1);
      do_read(32'h0000_0200, 1'b1, LAT + LW + 2, acc);
      chk_line("rd200", 32'hB000_0000, 32'hB111_0001, 32'hB222_0002, 32'hB333_0003);

      do_read(32'h0000_010C, 1'b1, LAT + LW + 2, acc);
`ifdef CRITICAL_WORD_FIRST_EN
      chk_line("rd10c", 32'hA3A3_3333, 32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222);
`else
      chk_line("rd10c", 32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333);
`endif

      acc_log.delete();
      log_acc   = 1'b1;
      req_we    = 1'b0;
      req_addr  = 32'h0000_0040;
      req_valid = 1'b1;
      repeat (20) begin
         @(posedge clk);
         #2;
      end
      req_valid = 1'b0;
      log_acc   = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #2;
      end
      chk32("held_accept_count", acc_log.size(), 3);
      if (acc_log.size() >= 2) chk32("held_accept_gap", acc_log[1] - acc_log[0], 9);

      wbuf[0] = 32'hC0C0_C0C0;
      wbuf[1] = 32'hC1C1_C1C1;
      wbuf[2] = 32'hC2C2_C2C2;
      wbuf[3] = 32'hC3C3_C3C3;
      do_write(32'h0000_1000, 0, 1'b0);
      do_read(32'h0000_0000, 1'b1, LAT + LW + 2, acc);
      chk_line("alias0", 32'hC0C0_C0C0, 32'hC1C1_C1C1, 32'hC2C2_C2C2, 32'hC3C3_C3C3);

      // Reset in the middle of a refill, right after the second beat.
      do_read(32'h0000_0100, 1'b1, 0, acc);
      for (int i = 0; i < 20 && cap.size() < 2; i++) begin
         @(negedge clk);
         #1;
      end
      reset = 1'b1;
      #1;
      chk1("midrst_rvalid", rvalid, 1'b0);
      chk1("midrst_req_ready", req_ready, 1'b1);
      chk1("midrst_rlast", rlast, 1'b0);
      chk32("midrst_rdata", rdata, 32'h0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #2;
      end
      chk32("midrst_beats", cap.size(), 2);
      chk32("midrst_no_rlast", last_pos, -1);

      for (int k = 0; k < 150; k++) begin
         a = $urandom;
         if ($urandom % 2 == 1) begin
            for (int i = 0; i < LW; i++) wbuf[i] = $urandom;
            do_write(a, int'($urandom % 2), 1'b0);
         end else begin
            do_read(a, 1'b0, 0, acc);
         end
         n = $urandom_range(0, 2);
         repeat (n) begin
            @(posedge clk);
            #2;
         end
      end
      repeat (15) begin
         @(posedge clk);
         #2;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
